rx78_ram_upload: RTL and testbench

Serves HPS upload (core to HPS) requests for the RX-78 core: when the HPS reads a file on a matching `ioctl_index`, this block fetches each requested byte from core memory and returns it on `ioctl_din`. The main use is saving the EXT RAM image. It is the read-direction counterpart of the cartridge download path. It sits between `hps_io` and the memory arbiter in `clk_sys`, and competes with the CPU for memory through a request/acknowledge handshake.

---
 rtl/rx78_pkg.sv | 14 +
 rtl/upl_lat_cnt.sv | 34 +++
 rtl/rx78_ram_upload.sv | 182 ++++++++++++++++++
 tb/tb_rx78_ram_upload.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx78_pkg.sv
// Shared definitions for the RX-78 core's HPS upload path.
package rx78_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StLat,
        StDone
    } upl_state_t;

    localparam logic [7:0] UPL_IDX_EXTRAM = 8'h02;
    localparam logic [7:0] UPL_FILL       = 8'hFF;

endpackage

// File: rtl/upl_lat_cnt.sv
// Loadable down-counter with zero flag; times the memory read latency.
module upl_lat_cnt #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rx78_ram_upload.sv
// HPS upload responder: fetches each requested byte from core memory and returns it on ioctl_din.
module rx78_ram_upload
    import rx78_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter logic [7:0]  INDEX  = UPL_IDX_EXTRAM,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_q,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    output logic              overrun
);

    localparam int unsigned    CntW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0] LatLoad = CntW'(RD_LAT - 1);
    localparam logic [ADDR_W:0] CountMax = {1'b1, {ADDR_W{1'b0}}};

    upl_state_t        state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic              ovr_q, ovr_d;
    logic              active_q;
    logic              fill_q, fill_d;
    logic              abort_q, abort_d;

    logic              active;
    logic              in_range;
    logic              cnt_load;
    logic [CntW-1:0]   cnt_load_val;
    logic              cnt_zero;

    assign active   = ioctl_upload && (ioctl_index == INDEX);
    assign in_range = ((ioctl_addr >> ADDR_W) == '0);

    upl_lat_cnt #(
        .Width (CntW)
    ) u_lat_cnt (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (state_q == StLat),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        wait_d       = wait_q;
        req_d        = req_q;
        addr_d       = addr_q;
        count_d      = count_q;
        sum_d        = sum_q;
        ovr_d        = ovr_q;
        fill_d       = fill_q;
        abort_d      = abort_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        unique case (state_q)
            StIdle: begin
                if (active && ioctl_rd) begin
                    wait_d  = 1'b1;
                    abort_d = 1'b0;
                    if (in_range) begin
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        req_d   = 1'b1;
                        fill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        // Out-of-range: one zero-length LAT pass substitutes the fill byte.
                        fill_d       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
                        state_d      = StLat;
                    end
                end
            end
            StReq: begin
                // A grant that coincides with session end still owns a read slot.
                if (mem_ack) begin
                    req_d        = 1'b0;
                    abort_d      = !active;
                    cnt_load     = 1'b1;
                    cnt_load_val = LatLoad;
                    state_d      = StLat;
                end else if (!active) begin
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StLat: begin
                if (!active) begin
                    abort_d = 1'b1;
                end
                if (cnt_zero) begin
                    if (abort_d) begin
                        wait_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        din_d   = fill_q ? UPL_FILL : mem_q;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                wait_d  = 1'b0;
                state_d = StIdle;
                if (active) begin
                    if (count_q != CountMax) begin
                        count_d = count_q + (ADDR_W+1)'(1);
                    end
                    sum_d = sum_q + din_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (active && !active_q) begin
            count_d = '0;
            sum_d   = '0;
            ovr_d   = 1'b0;
        end
        if (active && ioctl_rd && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            din_q    <= '0;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            ovr_q    <= 1'b0;
            active_q <= 1'b0;
            fill_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            ovr_q    <= ovr_d;
            active_q <= active;
            fill_q   <= fill_d;
            abort_q  <= abort_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign byte_count = count_q;
    assign checksum   = sum_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_rx78_ram_upload.sv
// Directed bench for rx78_ram_upload with a simple arbiter and fixed-latency memory model.
module tb_rx78_ram_upload;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_q;
    logic [ADDR_W:0]   byte_count;
    logic [7:0]        checksum;
    logic              overrun;

    int vectors = 0;
    int errors  = 0;

    int                ack_delay  = 0;
    int                req_cycles = 0;
    int                req_issues = 0;
    logic              req_prev   = 1'b0;
    logic [RD_LAT-1:0] ack_sr     = '0;
    logic [ADDR_W-1:0] addr_sr [RD_LAT];

    always #5 clk = ~clk;

    rx78_ram_upload #(
        .ADDR_W (ADDR_W),
        .INDEX  (8'h02),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_q        (mem_q),
        .byte_count   (byte_count),
        .checksum     (checksum),
        .overrun      (overrun)
    );

    // Memory contents: byte = addr[7:0] ^ 0x4A, so address 0x0010 holds 0x5A.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h4A;
    endfunction

    // Arbiter grants after ack_delay cycles of a pending request.
    assign mem_ack = mem_req && (req_cycles == ack_delay);
    // Data is valid only in the single cycle RD_LAT after the grant; junk otherwise.
    assign mem_q   = ack_sr[RD_LAT-1] ? mem_byte(addr_sr[RD_LAT-1]) : 8'hA5;

    always @(posedge clk) begin
        req_cycles <= (mem_req && !mem_ack) ? req_cycles + 1 : 0;
        req_prev   <= mem_req;
        if (mem_req && !req_prev) req_issues <= req_issues + 1;
        ack_sr     <= {ack_sr[RD_LAT-2:0], mem_ack};
        addr_sr[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) addr_sr[i] <= addr_sr[i-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses ioctl_rd in cycle T; returns at the sampling point of cycle T+1.
    task automatic do_read(input logic [24:0] addr);
        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        @(negedge clk);
        ioctl_rd   = 1'b0;
    endtask

    task automatic run_wait(input logic [ADDR_W-1:0] exp_addr, output int n, output int req_n,
                            output int addr_bad, output logic [7:0] last_din);
        n = 0; req_n = 0; addr_bad = 0; last_din = 8'h00;
        while (ioctl_wait && n < 60) begin
            n++;
            last_din = ioctl_din;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== exp_addr) addr_bad++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int         n, req_n, addr_bad, issues0;
        logic [7:0] last_din;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'h02;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        repeat (2) @(negedge clk);
        chk("rst_din",   ioctl_din,  0);
        chk("rst_wait",  ioctl_wait, 0);
        chk("rst_req",   mem_req,    0);
        chk("rst_addr",  mem_addr,   0);
        chk("rst_count", byte_count, 0);
        chk("rst_sum",   checksum,   0);
        chk("rst_ovr",   overrun,    0);
        reset_n      = 1'b1;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait read of 0x0010 -> 0x5A, wait high for RD_LAT+2 = 4 cycles.
        issues0 = req_issues;
        do_read(25'h0010);
        chk("t1_wait_t1", ioctl_wait, 1);
        chk("t1_req_t1",  mem_req,    1);
        chk("t1_addr",    mem_addr,   15'h0010);
        run_wait(15'h0010, n, req_n, addr_bad, last_din);
        chk("t1_wait_len", n,          4);
        chk("t1_din_done", last_din,   8'h5A);
        chk("t1_din",      ioctl_din,  8'h5A);
        chk("t1_count",    byte_count, 1);
        chk("t1_sum",      checksum,   8'h5A);
        chk("t1_issues",   req_issues - issues0, 1);

        // Grant delayed 5 cycles: req held 6 cycles, wait 9; 0x0123 -> 0x69, sum 0xC3.
        ack_delay = 5;
        issues0   = req_issues;
        do_read(25'h0123);
        run_wait(15'h0123, n, req_n, addr_bad, last_din);
        chk("t2_req_len",  req_n,      6);
        chk("t2_addr_bad", addr_bad,   0);
        chk("t2_wait_len", n,          9);
        chk("t2_din",      ioctl_din,  8'h69);
        chk("t2_count",    byte_count, 2);
        chk("t2_sum",      checksum,   8'hC3);
        chk("t2_issues",   req_issues - issues0, 1);
        ack_delay = 0;

        // Out-of-range 0x8000: no request, wait 2 cycles, FF; sum 0xC3+0xFF = 0xC2.
        issues0 = req_issues;
        do_read(25'h0008000);
        chk("t3_din_t1", ioctl_din, 8'h69);
        run_wait(15'h0000, n, req_n, addr_bad, last_din);
        chk("t3_wait_len", n,          2);
        chk("t3_req_n",    req_n,      0);
        chk("t3_din_done", last_din,   8'hFF);
        chk("t3_din",      ioctl_din,  8'hFF);
        chk("t3_count",    byte_count, 3);
        chk("t3_sum",      checksum,   8'hC2);
        chk("t3_issues",   req_issues - issues0, 0);

        // Second strobe during LAT: overrun, one request, 0x0200 -> 0x4A, sum 0x0C.
        issues0 = req_issues;
        do_read(25'h0200);
        @(negedge clk);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0300;
        @(negedge clk);
        ioctl_rd   = 1'b0;
        run_wait(15'h0200, n, req_n, addr_bad, last_din);
        chk("t4_ovr",   overrun,    1);
        chk("t4_din",   ioctl_din,  8'h4A);
        chk("t4_count", byte_count, 4);
        chk("t4_sum",   checksum,   8'h0C);
        repeat (5) @(negedge clk);
        chk("t4_wait_after", ioctl_wait, 0);
        chk("t4_issues",     req_issues - issues0, 1);
        ioctl_upload = 1'b0;
        @(negedge clk);
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_ovr_clr",   overrun,    0);
        chk("t4_count_clr", byte_count, 0);
        chk("t4_sum_clr",   checksum,   0);

        // Session dropped while in REQ: back to IDLE next cycle, nothing counted.
        ack_delay = 100;
        do_read(25'h0010);
        chk("t5_req_t1", mem_req, 1);
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("t5_wait", ioctl_wait, 0);
        chk("t5_req",  mem_req,    0);
        chk("t5_count", byte_count, 0);
        chk("t5_sum",   checksum,   0);
        ack_delay    = 0;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);

        // Session dropped in LAT: countdown finishes (2 more wait cycles), data discarded.
        do_read(25'h0010);
        @(negedge clk);
        ioctl_upload = 1'b0;
        run_wait(15'h0010, n, req_n, addr_bad, last_din);
        chk("t6_wait_len", n,          2);
        chk("t6_wait",     ioctl_wait, 0);
        chk("t6_din",      ioctl_din,  8'h4A);
        chk("t6_count",    byte_count, 0);
        chk("t6_sum",      checksum,   0);

        // Wrong index: strobe ignored entirely.
        issues0      = req_issues;
        ioctl_index  = 8'h01;
        ioctl_upload = 1'b1;
        do_read(25'h0010);
        chk("t7_wait_t1", ioctl_wait, 0);
        repeat (3) @(negedge clk);
        chk("t7_wait",   ioctl_wait, 0);
        chk("t7_issues", req_issues - issues0, 0);
        chk("t7_ovr",    overrun,    0);

        // Asynchronous reset in the middle of LAT.
        ioctl_index = 8'h02;
        repeat (2) @(negedge clk);
        do_read(25'h0010);
        run_wait(15'h0010, n, req_n, addr_bad, last_din);
        chk("t8_count_pre", byte_count, 1);
        do_read(25'h0020);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t8_din",   ioctl_din,  0);
        chk("t8_wait",  ioctl_wait, 0);
        chk("t8_req",   mem_req,    0);
        chk("t8_addr",  mem_addr,   0);
        chk("t8_count", byte_count, 0);
        chk("t8_sum",   checksum,   0);
        chk("t8_ovr",   overrun,    0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Recovery after reset: 0x0030 -> 0x7A.
        do_read(25'h0030);
        run_wait(15'h0030, n, req_n, addr_bad, last_din);
        chk("t9_wait_len", n,          4);
        chk("t9_din",      ioctl_din,  8'h7A);
        chk("t9_count",    byte_count, 1);
        chk("t9_sum",      checksum,   8'h7A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
